// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default datapath/control widths and the
// operand-forwarding select encoding used by the ID/EX stage.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    // Where a source operand came from, highest priority first.
    typedef enum logic [2:0] {
        FWD_ZERO,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_RF
    } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one source register.
// Ports:
//   i_rs                      source register index
//   i_ex_fwd_en               EX holds a valid, writing, non-load instruction
//   i_ex_rd / i_ex_result     EX destination and combinational ALU result
//   i_mem_we/i_mem_rd/i_mem_data  MEM writeback candidate
//   i_wb_we/i_wb_rd/i_wb_data     register-file write port
//   i_rf_data                 register-file read data for i_rs
//   o_sel                     chosen source
//   o_val                     forwarded operand value
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [4:0]   i_rs,
    input  logic         i_ex_fwd_en,
    input  logic [4:0]   i_ex_rd,
    input  logic [W-1:0] i_ex_result,
    input  logic         i_mem_we,
    input  logic [4:0]   i_mem_rd,
    input  logic [W-1:0] i_mem_data,
    input  logic         i_wb_we,
    input  logic [4:0]   i_wb_rd,
    input  logic [W-1:0] i_wb_data,
    input  logic [W-1:0] i_rf_data,
    output fwd_sel_e     o_sel,
    output logic [W-1:0] o_val
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_rs == 5'd0)
            o_sel = FWD_ZERO;
        else if (i_ex_fwd_en && (i_ex_rd == i_rs))
            o_sel = FWD_EX;
        else if (i_mem_we && (i_mem_rd == i_rs))
            o_sel = FWD_MEM;
        else if (i_wb_we && (i_wb_rd == i_rs))
            o_sel = FWD_WB;
    end

    always_comb begin
        o_val = i_rf_data;
        case (o_sel)
            FWD_ZERO: o_val = '0;
            FWD_EX:   o_val = i_ex_result;
            FWD_MEM:  o_val = i_mem_data;
            FWD_WB:   o_val = i_wb_data;
            default:  o_val = i_rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX operand-capture stage: forwards in-flight results into the source
// operands, detects load-use hazards (one bubble + IF/ID stall), honours
// flush and downstream stall, and keeps saturating tracer counters.
// Ports:
//   cpu_clk, cpu_rst          clock, synchronous active-high reset
//   id_*                      decoded instruction and register-file read data
//   ex_result                 combinational result of the instruction in EX
//   mem_*, wb_*               MEM / WB writeback candidates
//   flush, ex_stall           kill incoming instruction / hold ID/EX
//   ex_*                      registered ID/EX pipeline register
//   id_stall                  combinational hold request for IF/ID and PC
//   load_use_cnt, stall_cnt   saturating tracer counters
module id_ex_stage #(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              id_valid,
    input  logic              id_reg_we,
    input  logic              id_is_load,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   data_R1,
    input  logic [XLEN-1:0]   data_R2,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              mem_reg_we,
    input  logic [4:0]        mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_reg_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              ex_valid,
    output logic              ex_reg_we,
    output logic              ex_is_load,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              id_stall,
    output logic [CNT_W-1:0]  load_use_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    import pipe_pkg::*;

    logic              r_valid;
    logic              r_reg_we;
    logic              r_is_load;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [XLEN-1:0]   r_rs1_val;
    logic [XLEN-1:0]   r_rs2_val;
    logic [4:0]        r_rd;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_load_use_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_ex_fwd_en;
    logic              w_load_use;
    logic              w_id_stall;
    fwd_sel_e          w_rs1_sel;
    fwd_sel_e          w_rs2_sel;
    logic [XLEN-1:0]   w_rs1_mux;
    logic [XLEN-1:0]   w_rs2_mux;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;

    // A load in EX has no data yet, so it is never an EX forwarding source.
    assign w_ex_fwd_en = r_valid & r_reg_we & ~r_is_load;

    fwd_mux #(.W(XLEN)) u_fwd_rs1 (
        .i_rs        (id_rs1),
        .i_ex_fwd_en (w_ex_fwd_en),
        .i_ex_rd     (r_rd),
        .i_ex_result (ex_result),
        .i_mem_we    (mem_reg_we),
        .i_mem_rd    (mem_rd),
        .i_mem_data  (mem_data),
        .i_wb_we     (wb_reg_we),
        .i_wb_rd     (wb_rd),
        .i_wb_data   (wb_data),
        .i_rf_data   (data_R1),
        .o_sel       (w_rs1_sel),
        .o_val       (w_rs1_mux)
    );

    fwd_mux #(.W(XLEN)) u_fwd_rs2 (
        .i_rs        (id_rs2),
        .i_ex_fwd_en (w_ex_fwd_en),
        .i_ex_rd     (r_rd),
        .i_ex_result (ex_result),
        .i_mem_we    (mem_reg_we),
        .i_mem_rd    (mem_rd),
        .i_mem_data  (mem_data),
        .i_wb_we     (wb_reg_we),
        .i_wb_rd     (wb_rd),
        .i_wb_data   (wb_data),
        .i_rf_data   (data_R2),
        .o_sel       (w_rs2_sel),
        .o_val       (w_rs2_mux)
    );

    // x0 is hardwired: gate on the select so a zero source never depends on
    // the value mux.
    assign w_rs1_val = (w_rs1_sel == FWD_ZERO) ? '0 : w_rs1_mux;
    assign w_rs2_val = (w_rs2_sel == FWD_ZERO) ? '0 : w_rs2_mux;

    assign w_load_use = id_valid & r_valid & r_is_load & r_reg_we & (r_rd != 5'd0)
                      & ((id_use_rs1 & (id_rs1 == r_rd)) | (id_use_rs2 & (id_rs2 == r_rd)));

    // Flush discards the incoming instruction, so there is nothing to hold.
    assign w_id_stall = ~flush & (ex_stall | w_load_use);

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_valid        <= 1'b0;
            r_reg_we       <= 1'b0;
            r_is_load      <= 1'b0;
            r_pc           <= '0;
            r_imm          <= '0;
            r_rs1_val      <= '0;
            r_rs2_val      <= '0;
            r_rd           <= '0;
            r_ctrl         <= '0;
            r_load_use_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_id_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);

            if (flush) begin
                r_valid   <= 1'b0;
                r_reg_we  <= 1'b0;
                r_is_load <= 1'b0;
            end else if (!ex_stall) begin
                if (w_load_use) begin
                    r_valid   <= 1'b0;
                    r_reg_we  <= 1'b0;
                    r_is_load <= 1'b0;
                    if (r_load_use_cnt != '1)
                        r_load_use_cnt <= r_load_use_cnt + CNT_W'(1);
                end else begin
                    r_valid   <= id_valid;
                    r_reg_we  <= id_reg_we & id_valid;
                    r_is_load <= id_is_load & id_valid;
                    r_pc      <= id_pc;
                    r_imm     <= id_imm;
                    r_rs1_val <= w_rs1_val;
                    r_rs2_val <= w_rs2_val;
                    r_rd      <= id_rd;
                    r_ctrl    <= id_ctrl;
                end
            end
        end
    end

    assign ex_valid     = r_valid;
    assign ex_reg_we    = r_reg_we;
    assign ex_is_load   = r_is_load;
    assign ex_pc        = r_pc;
    assign ex_imm       = r_imm;
    assign ex_rs1_val   = r_rs1_val;
    assign ex_rs2_val   = r_rs2_val;
    assign ex_rd        = r_rd;
    assign ex_ctrl      = r_ctrl;
    assign id_stall     = w_id_stall;
    assign load_use_cnt = r_load_use_cnt;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              cpu_clk = 1'b0;
    logic              cpu_rst;
    logic              id_valid, id_reg_we, id_is_load, id_use_rs1, id_use_rs2;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0]   id_pc, id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   data_R1, data_R2, ex_result;
    logic              mem_reg_we;
    logic [4:0]        mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              wb_reg_we;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush, ex_stall;
    logic              ex_valid, ex_reg_we, ex_is_load;
    logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              id_stall;
    logic [CNT_W-1:0]  load_use_cnt, stall_cnt;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .id_valid(id_valid), .id_reg_we(id_reg_we), .id_is_load(id_is_load),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_pc(id_pc), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .data_R1(data_R1), .data_R2(data_R2), .ex_result(ex_result),
        .mem_reg_we(mem_reg_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_reg_we(wb_reg_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_stall(ex_stall),
        .ex_valid(ex_valid), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .id_stall(id_stall),
        .load_use_cnt(load_use_cnt), .stall_cnt(stall_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of what EX currently holds.
    logic              m_valid = 0, m_we = 0, m_load = 0;
    logic [XLEN-1:0]   m_pc = 0, m_imm = 0, m_rs1 = 0, m_rs2 = 0;
    logic [4:0]        m_rd = 0;
    logic [CTRL_W-1:0] m_ctrl = 0;
    int                m_lu_cnt = 0, m_st_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_operand(input logic [4:0] rs, input logic [XLEN-1:0] rf);
        if (rs == 0) return '0;
        if (m_valid && m_we && !m_load && m_rd == rs) return ex_result;
        if (mem_reg_we && mem_rd == rs) return mem_data;
        if (wb_reg_we && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    function automatic logic ref_load_use();
        if (!(id_valid && m_valid && m_load && m_we && m_rd != 0)) return 1'b0;
        return (id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd);
    endfunction

    function automatic logic ref_stall();
        return !flush && (ex_stall || ref_load_use());
    endfunction

    function automatic int sat(input int v);
        return (v >= int'(CNT_MAX)) ? int'(CNT_MAX) : v + 1;
    endfunction

    // One clock: check id_stall mid-cycle, advance the model at the edge,
    // then compare every registered output just after it.
    task automatic cycle();
        logic lu, st;
        logic [XLEN-1:0] v1, v2;
        @(negedge cpu_clk);
        lu = ref_load_use();
        st = ref_stall();
        v1 = ref_operand(id_rs1, data_R1);
        v2 = ref_operand(id_rs2, data_R2);
        if (!cpu_rst) check_val("id_stall", id_stall, st);
        @(posedge cpu_clk);
        if (cpu_rst) begin
            m_valid = 0; m_we = 0; m_load = 0; m_pc = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0; m_lu_cnt = 0; m_st_cnt = 0;
        end else begin
            if (st) m_st_cnt = sat(m_st_cnt);
            if (flush || (!ex_stall && lu)) begin
                m_valid = 0; m_we = 0; m_load = 0;
                if (!flush) m_lu_cnt = sat(m_lu_cnt);
            end else if (!ex_stall) begin
                m_valid = id_valid; m_we = id_reg_we && id_valid; m_load = id_is_load && id_valid;
                m_pc = id_pc; m_imm = id_imm; m_rs1 = v1; m_rs2 = v2; m_rd = id_rd; m_ctrl = id_ctrl;
            end
        end
        #1;
        check_val("ex_valid", ex_valid, m_valid);
        check_val("ex_reg_we", ex_reg_we, m_we);
        check_val("ex_is_load", ex_is_load, m_load);
        check_val("ex_pc", ex_pc, m_pc);
        check_val("ex_imm", ex_imm, m_imm);
        check_val("ex_rs1_val", ex_rs1_val, m_rs1);
        check_val("ex_rs2_val", ex_rs2_val, m_rs2);
        check_val("ex_rd", ex_rd, m_rd);
        check_val("ex_ctrl", ex_ctrl, m_ctrl);
        check_val("load_use_cnt", load_use_cnt, m_lu_cnt);
        check_val("stall_cnt", stall_cnt, m_st_cnt);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_reg_we = 0; id_is_load = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_pc = 0; id_imm = 0; id_ctrl = 0;
        data_R1 = 0; data_R2 = 0; ex_result = 0;
        mem_reg_we = 0; mem_rd = 0; mem_data = 0;
        wb_reg_we = 0; wb_rd = 0; wb_data = 0;
        flush = 0; ex_stall = 0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic u1, input logic u2);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_we = we; id_is_load = ld; id_use_rs1 = u1; id_use_rs2 = u2;
    endtask

    logic [XLEN-1:0] held_pc, held_rs1;

    initial begin
        idle_inputs();
        cpu_rst = 1;
        repeat (2) @(posedge cpu_clk);
        #1;
        check_val("rst_ex_valid", ex_valid, 0);
        check_val("rst_ex_pc", ex_pc, 0);
        check_val("rst_lu_cnt", load_use_cnt, 0);
        check_val("rst_stall_cnt", stall_cnt, 0);
        cpu_rst = 0;

        // Plain capture
        instr(5'd3, 5'd4, 5'd1, 0, 0, 1, 1);
        data_R1 = 32'h11; data_R2 = 32'h22; id_pc = 32'h40; id_imm = 32'h4; id_ctrl = 16'h1234;
        cycle();
        check_val("plain_valid", ex_valid, 1);
        check_val("plain_rs1", ex_rs1_val, 32'h11);

        // Forwarding priority
        instr(5'd0, 5'd0, 5'd5, 1, 0, 0, 0);
        cycle();
        instr(5'd5, 5'd0, 5'd9, 0, 0, 1, 0);
        data_R1 = 32'hDD; ex_result = 32'hA;
        mem_reg_we = 1; mem_rd = 5; mem_data = 32'hB;
        wb_reg_we = 1; wb_rd = 5; wb_data = 32'hC;
        cycle();
        check_val("prio_ex", ex_rs1_val, 32'hA);
        cycle();
        check_val("prio_mem", ex_rs1_val, 32'hB);
        mem_reg_we = 0;
        cycle();
        check_val("prio_wb", ex_rs1_val, 32'hC);
        id_rs1 = 0; mem_reg_we = 1; mem_rd = 0; wb_rd = 0;
        cycle();
        check_val("prio_x0", ex_rs1_val, 0);
        mem_reg_we = 0; wb_reg_we = 0;

        // Load-use
        instr(5'd0, 5'd0, 5'd7, 1, 1, 0, 0);
        cycle();
        instr(5'd1, 5'd7, 5'd8, 1, 0, 0, 1);
        data_R2 = 32'h99;
        #1 check_val("lu_id_stall", id_stall, 1);
        cycle();
        check_val("lu_bubble", ex_valid, 0);
        check_val("lu_cnt", load_use_cnt, 1);
        mem_reg_we = 1; mem_rd = 7; mem_data = 32'h55;
        #1 check_val("lu_release", id_stall, 0);
        cycle();
        check_val("lu_mem_fwd", ex_rs2_val, 32'h55);
        mem_reg_we = 0;

        // Flush beats stall and load-use
        instr(5'd0, 5'd0, 5'd7, 1, 1, 0, 0);
        cycle();
        instr(5'd2, 5'd7, 5'd3, 1, 0, 0, 1);
        flush = 1; ex_stall = 1;
        #1 check_val("flush_id_stall", id_stall, 0);
        cycle();
        check_val("flush_valid", ex_valid, 0);
        check_val("flush_lu_cnt", load_use_cnt, 1);
        flush = 0; ex_stall = 0;

        // Downstream stall, saturation, reset mid-stall
        cpu_rst = 1;
        cycle();
        cpu_rst = 0;
        instr(5'd6, 5'd0, 5'd4, 1, 0, 1, 0);
        id_pc = 32'h100; data_R1 = 32'h77;
        cycle();
        held_pc = ex_pc; held_rs1 = ex_rs1_val;
        ex_stall = 1; id_pc = 32'h104; data_R1 = 32'h88;
        repeat (3) cycle();
        check_val("stall_hold_pc", ex_pc, held_pc);
        check_val("stall_hold_rs1", ex_rs1_val, held_rs1);
        check_val("stall_cnt3", stall_cnt, 3);
        repeat (17) cycle();
        check_val("stall_sat", stall_cnt, 15);
        cpu_rst = 1;
        cycle();
        check_val("rst_mid_valid", ex_valid, 0);
        check_val("rst_mid_pc", ex_pc, 0);
        check_val("rst_mid_cnt", stall_cnt, 0);
        cpu_rst = 0; ex_stall = 0;
        #1 check_val("rst_mid_id_stall", id_stall, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            id_valid   = ($urandom_range(3) != 0);
            id_reg_we  = $urandom_range(1);
            id_is_load = ($urandom_range(2) == 0);
            id_use_rs1 = $urandom_range(1);
            id_use_rs2 = $urandom_range(1);
            id_rs1 = 5'($urandom_range(7));
            id_rs2 = 5'($urandom_range(7));
            id_rd  = 5'($urandom_range(7));
            id_pc = $urandom; id_imm = $urandom; id_ctrl = 16'($urandom);
            data_R1 = $urandom; data_R2 = $urandom; ex_result = $urandom;
            mem_reg_we = $urandom_range(1); mem_rd = 5'($urandom_range(7)); mem_data = $urandom;
            wb_reg_we = $urandom_range(1); wb_rd = 5'($urandom_range(7)); wb_data = $urandom;
            flush    = ($urandom_range(15) == 0);
            ex_stall = ($urandom_range(5) == 0);
            cpu_rst  = ($urandom_range(29) == 0);
            cycle();
        end
        cpu_rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
